// File: rtl/fp_mul_param.sv
// fp_mul_param: parametrised multicycle floating-point multiplier with start/done handshake.
// Iterative shift-add significand core, round-to-nearest-even, flush-to-zero on denormals.
// Optional inexact flag output nxf is enabled by defining FPMUL_INEXACT_EN.
module fp_mul_param #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [EXP_W+MAN_W:0]   p,
   output logic                   of,
   output logic                   uf,
   output logic                   nanf,
   output logic                   inff,
   output logic                   dnf,
   output logic                   zf
`ifdef FPMUL_INEXACT_EN
   ,
   output logic                   nxf
`endif
);

   localparam int unsigned W   = EXP_W + MAN_W + 1;
   localparam int unsigned SW  = MAN_W + 1;
   localparam int unsigned PW  = 2 * SW;
   localparam int unsigned EW  = EXP_W + 2;
   localparam int unsigned FW1 = MAN_W + 1;
   localparam int unsigned CW  = $clog2(MAN_W + 2);
   localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

   localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_CLASS, S_MUL, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t                  state;
   logic [W-1:0]            ra, rb;
   logic                    sign;
   logic [SW-1:0]           mcand;
   logic [PW-1:0]           prod;
   logic [CW-1:0]           cnt;
   logic signed [EW-1:0]    exp_r;
   logic [MAN_W-1:0]        frac_r;
   logic                    guard, sticky;

   // Operand field decode and classification
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb;
   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_den, b_den;
   logic nan_c, spec_c, sign_c;
   logic signed [EW-1:0] exp_sum_c;

   assign ea     = ra[W-2:MAN_W];
   assign eb     = rb[W-2:MAN_W];
   assign ma     = ra[MAN_W-1:0];
   assign mb     = rb[MAN_W-1:0];
   assign a_nan  = (&ea) & (|ma);
   assign b_nan  = (&eb) & (|mb);
   assign a_inf  = (&ea) & ~(|ma);
   assign b_inf  = (&eb) & ~(|mb);
   assign a_zero = ~(|ea);
   assign b_zero = ~(|eb);
   assign a_den  = a_zero & (|ma);
   assign b_den  = b_zero & (|mb);
   assign nan_c  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
   assign spec_c = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
   assign sign_c = ra[W-1] ^ rb[W-1];
   assign exp_sum_c = EW'(ea) + EW'(eb) - EW'(BIAS);

   // One shift-add step: conditionally add the multiplicand into the upper half, then shift right
   logic [SW:0] add_c;
   assign add_c = {1'b0, prod[PW-1:SW]} + (prod[0] ? {1'b0, mcand} : {(SW+1){1'b0}});

   // Normalisation of the raw product into fraction, guard and sticky
   logic [MAN_W-1:0]     nfrac_c;
   logic                 ng_c, ns_c;
   logic signed [EW-1:0] nexp_c;

   always_comb begin
      nfrac_c = prod[PW-3:SW-1];
      ng_c    = prod[SW-2];
      ns_c    = |prod[SW-3:0];
      nexp_c  = exp_r;
      if (prod[PW-1]) begin
         nfrac_c = prod[PW-2:SW];
         ng_c    = prod[SW-1];
         ns_c    = |prod[SW-2:0];
         nexp_c  = exp_r + EW'(1);
      end
   end

   // Round-to-nearest-even; a fraction carry-out means the significand became 2.0
   logic                 inc_c;
   logic [MAN_W:0]       rnd_c;
   logic signed [EW-1:0] rexp_c;
   logic                 of_c, uf_c;

   assign inc_c  = guard & (sticky | frac_r[0]);
   assign rnd_c  = {1'b0, frac_r} + FW1'(inc_c);
   assign rexp_c = rnd_c[MAN_W] ? exp_r + EW'(1) : exp_r;
   assign of_c   = rexp_c >= EXP_MAX;
   assign uf_c   = rexp_c <= EXP_ZERO;

   // Control FSM with registered datapath and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         ra     <= '0;
         rb     <= '0;
         sign   <= 1'b0;
         mcand  <= '0;
         prod   <= '0;
         cnt    <= '0;
         exp_r  <= '0;
         frac_r <= '0;
         guard  <= 1'b0;
         sticky <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         p      <= '0;
         of     <= 1'b0;
         uf     <= 1'b0;
         nanf   <= 1'b0;
         inff   <= 1'b0;
         dnf    <= 1'b0;
         zf     <= 1'b0;
`ifdef FPMUL_INEXACT_EN
         nxf    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  busy  <= 1'b1;
                  of    <= 1'b0;
                  uf    <= 1'b0;
                  nanf  <= 1'b0;
                  inff  <= 1'b0;
                  dnf   <= 1'b0;
                  zf    <= 1'b0;
`ifdef FPMUL_INEXACT_EN
                  nxf   <= 1'b0;
`endif
                  state <= S_CLASS;
               end
            end
            S_CLASS: begin
               sign <= sign_c;
               dnf  <= a_den | b_den;
               if (spec_c) begin
                  if (nan_c) begin
                     p    <= QNAN;
                     nanf <= 1'b1;
                  end else if (a_inf | b_inf) begin
                     p    <= {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                     inff <= 1'b1;
                  end else begin
                     p    <= {sign_c, {(W-1){1'b0}}};
                     zf   <= 1'b1;
                  end
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  mcand <= {1'b1, ma};
                  prod  <= {{SW{1'b0}}, 1'b1, mb};
                  cnt   <= CW'(MAN_W);
                  exp_r <= exp_sum_c;
                  state <= S_MUL;
               end
            end
            S_MUL: begin
               prod <= {add_c, prod[SW-1:1]};
               cnt  <= cnt - CW'(1);
               if (cnt == '0) state <= S_NORM;
            end
            S_NORM: begin
               frac_r <= nfrac_c;
               guard  <= ng_c;
               sticky <= ns_c;
               exp_r  <= nexp_c;
               state  <= S_ROUND;
            end
            S_ROUND: begin
               if (of_c) begin
                  p    <= {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  of   <= 1'b1;
                  inff <= 1'b1;
               end else if (uf_c) begin
                  p    <= {sign, {(W-1){1'b0}}};
                  uf   <= 1'b1;
                  zf   <= 1'b1;
               end else begin
                  p    <= {sign, rexp_c[EXP_W-1:0], rnd_c[MAN_W-1:0]};
               end
`ifdef FPMUL_INEXACT_EN
               nxf   <= guard | sticky | of_c | uf_c;
`endif
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mul_param.sv
// Directed testbench for fp_mul_param: single-precision and half-precision instances.
module tb_fp_mul_param;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        start_sp = 1'b0, start_hp = 1'b0;
   logic [31:0] a_sp = '0, b_sp = '0, p_sp;
   logic [15:0] a_hp = '0, b_hp = '0, p_hp;
   logic busy_sp, done_sp, of_sp, uf_sp, nanf_sp, inff_sp, dnf_sp, zf_sp;
   logic busy_hp, done_hp, of_hp, uf_hp, nanf_hp, inff_hp, dnf_hp, zf_hp;
   logic nxf_sp, nxf_hp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_mul_param u_sp (
      .clk(clk), .rst(rst), .start(start_sp), .a(a_sp), .b(b_sp),
      .busy(busy_sp), .done(done_sp), .p(p_sp),
      .of(of_sp), .uf(uf_sp), .nanf(nanf_sp), .inff(inff_sp), .dnf(dnf_sp), .zf(zf_sp)
`ifdef FPMUL_INEXACT_EN
      , .nxf(nxf_sp)
`endif
   );

   fp_mul_param #(.EXP_W(5), .MAN_W(10)) u_hp (
      .clk(clk), .rst(rst), .start(start_hp), .a(a_hp), .b(b_hp),
      .busy(busy_hp), .done(done_hp), .p(p_hp),
      .of(of_hp), .uf(uf_hp), .nanf(nanf_hp), .inff(inff_hp), .dnf(dnf_hp), .zf(zf_hp)
`ifdef FPMUL_INEXACT_EN
      , .nxf(nxf_hp)
`endif
   );

`ifndef FPMUL_INEXACT_EN
   assign nxf_sp = 1'b0;
   assign nxf_hp = 1'b0;
`endif

   // Selected-instance view used by the transaction task
   logic        half_sel = 1'b0;
   logic        cur_busy, cur_done, cur_nx;
   logic [31:0] cur_p;
   logic [5:0]  cur_fl;
   assign cur_busy = half_sel ? busy_hp : busy_sp;
   assign cur_done = half_sel ? done_hp : done_sp;
   assign cur_p    = half_sel ? {16'h0, p_hp} : p_sp;
   assign cur_nx   = half_sel ? nxf_hp : nxf_sp;
   assign cur_fl   = half_sel ? {of_hp, uf_hp, nanf_hp, inff_hp, dnf_hp, zf_hp}
                              : {of_sp, uf_sp, nanf_sp, inff_sp, dnf_sp, zf_sp};

   // Results of the last transaction
   int          r_lat;
   logic        r_gap, r_nx;
   logic [31:0] r_p;
   logic [5:0]  r_fl;
   logic [1:0]  r_after;

   // Issue one operation, scramble operand pins, wait (bounded) for done
   task automatic run_op(input logic half, input logic [31:0] av, input logic [31:0] bv);
      half_sel = half;
      if (half) begin
         a_hp = av[15:0]; b_hp = bv[15:0]; start_hp = 1'b1;
      end else begin
         a_sp = av; b_sp = bv; start_sp = 1'b1;
      end
      @(posedge clk); #1;
      start_sp = 1'b0; start_hp = 1'b0;
      a_sp = $urandom; b_sp = $urandom;
      a_hp = 16'($urandom); b_hp = 16'($urandom);
      r_lat = 0; r_gap = 1'b0; r_p = '0; r_fl = '0; r_nx = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (!cur_busy) r_gap = 1'b1;
         if (cur_done) begin
            r_lat = n; r_p = cur_p; r_fl = cur_fl; r_nx = cur_nx;
            break;
         end
      end
      @(negedge clk);
      r_after = {cur_busy, cur_done};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy_sp, done_sp, p_sp, of_sp, uf_sp, nanf_sp, inff_sp, dnf_sp, zf_sp, nxf_sp} !== '0) begin
         errors++;
         $display("FAIL reset_sp: got busy=%b done=%b p=%h flags=%b%b%b%b%b%b nx=%b want all 0",
                  busy_sp, done_sp, p_sp, of_sp, uf_sp, nanf_sp, inff_sp, dnf_sp, zf_sp, nxf_sp);
      end
      checks++;
      if ({busy_hp, done_hp, p_hp, of_hp, uf_hp, nanf_hp, inff_hp, dnf_hp, zf_hp, nxf_hp} !== '0) begin
         errors++;
         $display("FAIL reset_hp: got busy=%b done=%b p=%h want all 0", busy_hp, done_hp, p_hp);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Table-driven operation checks: product, flags, latency, busy envelope, inexact
   task automatic test_vectors(input string name, input logic half, input logic [31:0] av,
                               input logic [31:0] bv, input logic [31:0] ep, input logic [5:0] efl,
                               input int elat, input logic enx);
      run_op(half, av, bv);
      checks++;
      if (r_p !== ep) begin
         errors++; $display("FAIL %s_p: got %h want %h", name, r_p, ep);
      end
      checks++;
      if (r_fl !== efl) begin
         errors++; $display("FAIL %s_flags: got %b want %b (of uf nan inf dn z)", name, r_fl, efl);
      end
      checks++;
      if (r_lat != elat) begin
         errors++; $display("FAIL %s_latency: got %0d want %0d", name, r_lat, elat);
      end
      checks++;
      if (r_gap !== 1'b0 || r_after !== 2'b00) begin
         errors++; $display("FAIL %s_busy: got gap=%b after=%b want gap=0 after=00", name, r_gap, r_after);
      end
`ifdef FPMUL_INEXACT_EN
      checks++;
      if (r_nx !== enx) begin
         errors++; $display("FAIL %s_nxf: got %b want %b", name, r_nx, enx);
      end
`else
      if (enx && r_nx) $display("note: %s inexact", name);
`endif
   endtask

   task automatic test_normal();
      test_vectors("mul_1p5x2", 1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 6'b000000, 28, 1'b0);
   endtask

   task automatic test_specials();
      test_vectors("inf_x_zero", 1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 6'b001000, 2, 1'b0);
      test_vectors("ninf_x_one", 1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 6'b000100, 2, 1'b0);
      test_vectors("nan_x_one",  1'b0, 32'hFFC01234, 32'h3F800000, 32'h7FC00000, 6'b001000, 2, 1'b0);
   endtask

   task automatic test_range();
      test_vectors("overflow",  1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 6'b100100, 28, 1'b1);
      test_vectors("underflow", 1'b0, 32'h00800000, 32'h00800000, 32'h00000000, 6'b010001, 28, 1'b1);
      test_vectors("denormal",  1'b0, 32'h00000001, 32'h3F800000, 32'h00000000, 6'b000011, 2, 1'b0);
   endtask

   task automatic test_rounding();
      test_vectors("round_sticky", 1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 6'b000000, 28, 1'b1);
      test_vectors("round_near2",  1'b0, 32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 6'b000000, 28, 1'b1);
      test_vectors("round_carry",  1'b1, 32'h00003DA8, 32'h00003DA8, 32'h00004000, 6'b000000, 15, 1'b1);
   endtask

   task automatic test_half();
      test_vectors("half_neg2", 1'b1, 32'h00003C00, 32'h0000C000, 32'h0000C000, 6'b000000, 15, 1'b0);
      test_vectors("half_of",   1'b1, 32'h00007BFF, 32'h00007BFF, 32'h00007C00, 6'b100100, 15, 1'b1);
   endtask

   // start held high for 40 cycles: exactly two accepts, at cycle 0 and cycle 29
   task automatic test_back_to_back();
      int ndone = 0;
      int first = 0;
      int second = 0;
      a_sp = 32'h3FC00000; b_sp = 32'h40000000; start_sp = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if (done_sp) begin
            ndone++;
            if (ndone == 1) first = k;
            if (ndone == 2) second = k;
         end
         if (k == 39) start_sp = 1'b0;
      end
      checks++;
      if (ndone != 2 || first != 28 || second != 57) begin
         errors++;
         $display("FAIL back_to_back: got %0d dones at %0d,%0d want 2 at 28,57", ndone, first, second);
      end
      checks++;
      if (p_sp !== 32'h40400000) begin
         errors++; $display("FAIL back_to_back_p: got %h want 40400000", p_sp);
      end
   endtask

   // Reset during MUL aborts the operation; a later start still works
   task automatic test_reset_abort();
      int ndone = 0;
      half_sel = 1'b0;
      a_sp = 32'h3FC00000; b_sp = 32'h40000000; start_sp = 1'b1;
      @(posedge clk); #1;
      start_sp = 1'b0;
      repeat (11) @(negedge clk);
      checks++;
      if (busy_sp !== 1'b1) begin
         errors++; $display("FAIL abort_busy_before: got %b want 1", busy_sp);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy_sp, done_sp, p_sp, of_sp, uf_sp, nanf_sp, inff_sp, dnf_sp, zf_sp, nxf_sp} !== '0) begin
         errors++; $display("FAIL abort_outputs: got busy=%b done=%b p=%h want all 0", busy_sp, done_sp, p_sp);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done_sp) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++; $display("FAIL abort_no_done: got %0d dones want 0", ndone);
      end
      test_vectors("after_abort", 1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 6'b000000, 28, 1'b0);
   endtask

   initial begin
      test_reset();
      test_normal();
      test_specials();
      test_range();
      test_rounding();
      test_half();
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
